// File: rtl/vga_bounce_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : vga_bounce_sprite
//  Description : Pixel-colour stage for a VGA beam. Keeps a sprite that moves
//                once per frame, bounces off the active-area edges, changes
//                colour on every bounce, and produces registered 2-bit R/G/B
//                per pixel (1 clk latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_bounce_sprite #(
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int SPRITE_W         = 32,
    parameter int SPRITE_H         = 32,
    parameter int STEP             = 1,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       vsync,
    input  logic       pause,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       frame_tick,
    output logic       bounce,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y
);

    // 11-bit constants so edge comparisons can never wrap
    localparam logic [10:0] MAX_X    = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] MAX_Y    = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  STEP_N   = 10'(STEP);
    localparam logic [10:0] SPR_W_W  = 11'(SPRITE_W);
    localparam logic [10:0] SPR_H_W  = 11'(SPRITE_H);
    localparam logic        VS_IDLE  = (VSYNC_ACTIVE_LOW != 0);

    logic       vsync_q;
    logic       frame_tick_q;
    logic       bounce_q;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       dir_x_q, dir_x_d;   // 1 = moving towards larger coordinates
    logic       dir_y_q, dir_y_d;
    logic [2:0] colour_q;
    logic [5:0] rgb_q, rgb_d;

    logic        frame_start;
    logic        bounce_x, bounce_y;
    logic [10:0] x_inc, y_inc;
    logic        hit;

    // A frame starts on the first cycle vsync becomes active; a long pulse counts once
    assign frame_start = (vsync_q == VS_IDLE) && (vsync != VS_IDLE);

    assign x_inc = {1'b0, x_q} + STEP_W;
    assign y_inc = {1'b0, y_q} + STEP_W;

    // Next sprite position and direction for one frame of motion on each axis
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        bounce_x = 1'b0;
        bounce_y = 1'b0;

        if (dir_x_q) begin
            if (x_inc >= MAX_X) begin
                x_d      = MAX_X[9:0];
                dir_x_d  = 1'b0;
                bounce_x = 1'b1;
            end else begin
                x_d = x_inc[9:0];
            end
        end else begin
            if ({1'b0, x_q} <= STEP_W) begin
                x_d      = '0;
                dir_x_d  = 1'b1;
                bounce_x = 1'b1;
            end else begin
                x_d = x_q - STEP_N;
            end
        end

        if (dir_y_q) begin
            if (y_inc >= MAX_Y) begin
                y_d      = MAX_Y[9:0];
                dir_y_d  = 1'b0;
                bounce_y = 1'b1;
            end else begin
                y_d = y_inc[9:0];
            end
        end else begin
            if ({1'b0, y_q} <= STEP_W) begin
                y_d      = '0;
                dir_y_d  = 1'b1;
                bounce_y = 1'b1;
            end else begin
                y_d = y_q - STEP_N;
            end
        end
    end

    assign hit = ({1'b0, hpos} >= {1'b0, x_q}) &&
                 ({1'b0, hpos} <  ({1'b0, x_q} + SPR_W_W)) &&
                 ({1'b0, vpos} >= {1'b0, y_q}) &&
                 ({1'b0, vpos} <  ({1'b0, y_q} + SPR_H_W));

    // Pixel colour: blank outside active area, palette on sprite, dim checker elsewhere
    always_comb begin
        rgb_d = 6'b00_00_00;
        if (display_on) begin
            if (hit) begin
                case (colour_q)
                    3'd0:    rgb_d = 6'b11_00_00;
                    3'd1:    rgb_d = 6'b00_11_00;
                    3'd2:    rgb_d = 6'b00_00_11;
                    3'd3:    rgb_d = 6'b11_11_00;
                    3'd4:    rgb_d = 6'b00_11_11;
                    3'd5:    rgb_d = 6'b11_00_11;
                    3'd6:    rgb_d = 6'b11_11_11;
                    default: rgb_d = 6'b01_01_01;
                endcase
            end else begin
                rgb_d = {4'b00_00, 1'b0, hpos[5] ^ vpos[5]};
            end
        end
    end

    // State registers: motion and colour change only at frame start (during blanking)
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q      <= VS_IDLE;
            frame_tick_q <= 1'b0;
            bounce_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            colour_q     <= '0;
            rgb_q        <= '0;
        end else begin
            vsync_q      <= vsync;
            frame_tick_q <= frame_start;
            bounce_q     <= frame_start && !pause && (bounce_x || bounce_y);
            rgb_q        <= rgb_d;
            if (frame_start && !pause) begin
                x_q     <= x_d;
                y_q     <= y_d;
                dir_x_q <= dir_x_d;
                dir_y_q <= dir_y_d;
                // A corner hit still advances the colour only once
                if (bounce_x || bounce_y) begin
                    colour_q <= colour_q + 3'd1;
                end
            end
        end
    end

    assign r          = rgb_q[5:4];
    assign g          = rgb_q[3:2];
    assign b          = rgb_q[1:0];
    assign frame_tick = frame_tick_q;
    assign bounce     = bounce_q;
    assign sprite_x   = x_q;
    assign sprite_y   = y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_bounce_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_bounce_sprite
//  Description : Self-checking bench for vga_bounce_sprite (default geometry
//                plus a 64x64 instance for the corner-hit case).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_bounce_sprite;

    localparam int MAXX = 640 - 32;
    localparam int MAXY = 480 - 32;
    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       reset, display_on, vsync, pause;
    logic [9:0] hpos, vpos;
    logic [1:0] r, g, b, r2, g2, b2;
    logic       frame_tick, bounce, frame_tick2, bounce2;
    logic [9:0] sx, sy, sx2, sy2;

    vga_bounce_sprite dut (
        .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .vsync(vsync), .pause(pause), .r(r), .g(g), .b(b), .frame_tick(frame_tick),
        .bounce(bounce), .sprite_x(sx), .sprite_y(sy)
    );

    vga_bounce_sprite #(.H_ACTIVE(64), .V_ACTIVE(64), .SPRITE_W(32), .SPRITE_H(32)) dut2 (
        .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .vsync(vsync), .pause(pause), .r(r2), .g(g2), .b(b2), .frame_tick(frame_tick2),
        .bounce(bounce2), .sprite_x(sx2), .sprite_y(sy2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0, bnc_cnt = 0, bnc2_cnt = 0;

    // model of the default-geometry sprite
    int m_x, m_y, m_dx, m_dy, m_col, m_moves, m_b;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       bnc;
    } frame_exp_t;

    frame_exp_t fq[$];
    logic [5:0] pq[$];

    always @(negedge clk) begin
        if (frame_tick === 1'b1) tick_cnt++;
        if (bounce === 1'b1)     bnc_cnt++;
        if (bounce2 === 1'b1)    bnc2_cnt++;
    end

    function automatic logic [5:0] palette(input int c);
        case (c)
            0: return 6'b11_00_00;
            1: return 6'b00_11_00;
            2: return 6'b00_00_11;
            3: return 6'b11_11_00;
            4: return 6'b00_11_11;
            5: return 6'b11_00_11;
            6: return 6'b11_11_11;
            default: return 6'b01_01_01;
        endcase
    endfunction

    function automatic logic [5:0] exp_pix(input logic d, input logic [9:0] h, input logic [9:0] v);
        if (!d) return 6'b0;
        if (int'(h) >= m_x && int'(h) < m_x + 32 && int'(v) >= m_y && int'(v) < m_y + 32)
            return palette(m_col);
        return {5'b0, h[5] ^ v[5]};
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_col = 0; m_moves = 0; m_b = 0;
    endtask

    task automatic model_frame();
        int bx, by;
        bx = 0; by = 0;
        if (!pause) begin
            if (m_dx == 1) begin
                if (m_x + STEP >= MAXX) begin m_x = MAXX; m_dx = 0; bx = 1; end
                else m_x = m_x + STEP;
            end else begin
                if (m_x <= STEP) begin m_x = 0; m_dx = 1; bx = 1; end
                else m_x = m_x - STEP;
            end
            if (m_dy == 1) begin
                if (m_y + STEP >= MAXY) begin m_y = MAXY; m_dy = 0; by = 1; end
                else m_y = m_y + STEP;
            end else begin
                if (m_y <= STEP) begin m_y = 0; m_dy = 1; by = 1; end
                else m_y = m_y - STEP;
            end
            if (bx != 0 || by != 0) m_col = (m_col + 1) % 8;
            m_moves++;
        end
        m_b = (bx != 0 || by != 0) ? 1 : 0;
    endtask

    // one vsync pulse (active low, one clk wide); checks the frame update
    task automatic do_frame();
        frame_exp_t e;
        @(negedge clk);
        vsync = 1'b0;
        model_frame();
        e.x = 10'(m_x); e.y = 10'(m_y); e.bnc = (m_b != 0);
        fq.push_back(e);
        @(negedge clk);
        vsync = 1'b1;
        e = fq.pop_front();
        checks++;
        if (sx !== e.x) begin errors++; $display("FAIL frame_x: got %0d expected %0d", sx, e.x); end
        checks++;
        if (sy !== e.y) begin errors++; $display("FAIL frame_y: got %0d expected %0d", sy, e.y); end
        checks++;
        if (bounce !== e.bnc) begin errors++; $display("FAIL frame_bounce: got %b expected %b", bounce, e.bnc); end
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL frame_tick_high: got %b expected 1", frame_tick); end
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL frame_tick_low: got %b expected 0", frame_tick); end
    endtask

    task automatic pix_step(input logic d, input logic [9:0] h, input logic [9:0] v);
        logic [5:0] e;
        @(negedge clk);
        if (pq.size() > 0) begin
            e = pq.pop_front();
            checks++;
            if ({r, g, b} !== e) begin errors++; $display("FAIL pixel: got %b expected %b", {r, g, b}, e); end
        end
        display_on = d; hpos = h; vpos = v;
        pq.push_back(exp_pix(d, h, v));
    endtask

    task automatic pix_flush();
        logic [5:0] e;
        @(negedge clk);
        while (pq.size() > 0) begin
            e = pq.pop_front();
            checks++;
            if ({r, g, b} !== e) begin errors++; $display("FAIL pixel_last: got %b expected %b", {r, g, b}, e); end
        end
        display_on = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b1; pause = 1'b0; display_on = 1'b1; hpos = 0; vpos = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b0) begin errors++; $display("FAIL reset_rgb: got %b expected 0", {r, g, b}); end
        checks++;
        if (sx !== 10'd0 || sy !== 10'd0) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", sx, sy); end
        checks++;
        if (frame_tick !== 1'b0 || bounce !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", frame_tick, bounce); end
        reset = 1'b0; display_on = 1'b0;
        tick_cnt = 0; bnc_cnt = 0; bnc2_cnt = 0;
        model_reset();
        do_frame();
        checks++;
        if (sx !== 10'd1 || sy !== 10'd1) begin errors++; $display("FAIL first_move: got %0d,%0d expected 1,1", sx, sy); end
        checks++;
        if (tick_cnt != 1 || bnc_cnt != 0) begin errors++; $display("FAIL first_counts: got ticks %0d bounces %0d expected 1 0", tick_cnt, bnc_cnt); end
    endtask

    task automatic test_corner();
        repeat (31) do_frame();
        checks++;
        if (sx2 !== 10'd32 || sy2 !== 10'd32) begin errors++; $display("FAIL corner_pos: got %0d,%0d expected 32,32", sx2, sy2); end
        checks++;
        if (bnc2_cnt != 1) begin errors++; $display("FAIL corner_bounce_cnt: got %0d expected 1", bnc2_cnt); end
        @(negedge clk);
        display_on = 1'b1; hpos = 10'd32; vpos = 10'd32;
        @(negedge clk);
        checks++;
        if ({r2, g2, b2} !== 6'b00_11_00) begin errors++; $display("FAIL corner_colour: got %b expected 001100", {r2, g2, b2}); end
        display_on = 1'b0;
        do_frame();
        checks++;
        if (sx2 !== 10'd31 || sy2 !== 10'd31) begin errors++; $display("FAIL corner_flip: got %0d,%0d expected 31,31", sx2, sy2); end
    endtask

    task automatic test_pixel();
        // sprite at (33,33), colour 0
        pix_step(1'b1, 10'd33,  10'd33);
        pix_step(1'b1, 10'd64,  10'd64);
        pix_step(1'b1, 10'd65,  10'd33);
        pix_step(1'b1, 10'd33,  10'd65);
        pix_step(1'b1, 10'd32,  10'd40);
        pix_step(1'b0, 10'd33,  10'd33);
        pix_step(1'b1, 10'd100, 10'd200);
        pix_step(1'b1, 10'd100, 10'd10);
        pix_flush();
    endtask

    task automatic test_pause();
        int t0, x0, y0;
        t0 = tick_cnt; x0 = m_x; y0 = m_y;
        pause = 1'b1;
        repeat (10) do_frame();
        checks++;
        if (tick_cnt != t0 + 10) begin errors++; $display("FAIL pause_ticks: got %0d expected %0d", tick_cnt, t0 + 10); end
        checks++;
        if (int'(sx) != x0 || int'(sy) != y0) begin errors++; $display("FAIL pause_hold: got %0d,%0d expected %0d,%0d", sx, sy, x0, y0); end
        pause = 1'b0;
        do_frame();
        checks++;
        if (int'(sx) != x0 + STEP || int'(sy) != y0 + STEP) begin errors++; $display("FAIL pause_release: got %0d,%0d expected %0d,%0d", sx, sy, x0 + STEP, y0 + STEP); end
    endtask

    task automatic test_long_run();
        while (m_moves < 608) begin
            do_frame();
            if (m_moves == 448) begin
                checks++;
                if (sy !== 10'd448 || bnc_cnt != 1) begin errors++; $display("FAIL y_bounce: got y %0d bounces %0d expected 448 1", sy, bnc_cnt); end
            end
        end
        checks++;
        if (sx !== 10'd608 || sy !== 10'd288) begin errors++; $display("FAIL x_bounce_pos: got %0d,%0d expected 608,288", sx, sy); end
        checks++;
        if (bnc_cnt != 2) begin errors++; $display("FAIL x_bounce_cnt: got %0d expected 2", bnc_cnt); end
        @(negedge clk);
        display_on = 1'b1; hpos = 10'd608; vpos = 10'd288;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b00_00_11) begin errors++; $display("FAIL colour_after_608: got %b expected 000011", {r, g, b}); end
        display_on = 1'b0;
        do_frame();
        checks++;
        if (sx !== 10'd607) begin errors++; $display("FAIL x_reverse: got %0d expected 607", sx); end
    endtask

    task automatic test_vsync_hold_reset();
        int t0;
        t0 = tick_cnt;
        @(negedge clk);
        vsync = 1'b0;
        repeat (800) @(negedge clk);
        checks++;
        if (tick_cnt != t0 + 1) begin errors++; $display("FAIL long_vsync_ticks: got %0d expected %0d", tick_cnt, t0 + 1); end
        display_on = 1'b1; hpos = 10'(m_x); vpos = 10'(m_y);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sx !== 10'd0 || sy !== 10'd0) begin errors++; $display("FAIL midframe_reset_pos: got %0d,%0d expected 0,0", sx, sy); end
        checks++;
        if ({r, g, b} !== 6'b0) begin errors++; $display("FAIL midframe_reset_rgb: got %b expected 0", {r, g, b}); end
        vsync = 1'b1; reset = 1'b0; display_on = 1'b0;
        model_reset();
        pix_step(1'b1, 10'd0, 10'd0);
        pix_step(1'b1, 10'd31, 10'd31);
        pix_flush();
        checks++;
        if (tick_cnt != t0 + 1) begin errors++; $display("FAIL post_reset_ticks: got %0d expected %0d", tick_cnt, t0 + 1); end
    endtask

    initial begin
        reset = 1'b1; display_on = 1'b0; hpos = 0; vpos = 0; vsync = 1'b1; pause = 1'b0;
        model_reset();
        test_reset();
        test_corner();
        test_pixel();
        test_pause();
        test_long_run();
        test_vsync_hold_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
